// File: rtl/mips_registers_pkg.sv
// Shared MIPS constants: datapath width, register-index width and the hard-wired zero register.
package mips_registers_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_registers_reg32_en.sv
// One architectural register: synchronous active-high clear, load when enabled.
module reg32_en #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mips_registers.sv
// MIPS 32-entry register file: two asynchronous read ports, one synchronous write port, r0 tied to zero.
module mips_registers
    import mips_registers_pkg::*;
#(
    parameter int DATA_W = mips_registers_pkg::DATA_W,
    parameter int ADDR_W = mips_registers_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int N_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [0:N_REGS-1];
    logic              we   [1:N_REGS-1];

    assign regs[REG_ZERO] = '0;

    // Decoder output for index 0 does not exist, so writes to r0 fall on the floor.
    genvar gi;
    generate
        for (gi = 1; gi < N_REGS; gi++) begin : g_reg
            assign we[gi] = reg_write && (write_reg == ADDR_W'(gi));

            reg32_en #(
                .DATA_W (DATA_W)
            ) u_reg (
                .clk  (clk),
                .srst (reset),
                .en   (we[gi]),
                .d    (write_data),
                .q    (regs[gi])
            );
        end
    endgenerate

    // Read ports: binary tree of 2:1 muxes, level gl steered by address bit gl.
    genvar gl;
    generate
        for (gl = 0; gl < ADDR_W; gl++) begin : lvl
            localparam int N_NODES = N_REGS >> (gl + 1);
            logic [DATA_W-1:0] n1 [0:N_NODES-1];
            logic [DATA_W-1:0] n2 [0:N_NODES-1];

            for (gi = 0; gi < N_NODES; gi++) begin : node
                if (gl == 0) begin : g_leaf
                    assign n1[gi] = read_reg1[0] ? regs[2*gi+1] : regs[2*gi];
                    assign n2[gi] = read_reg2[0] ? regs[2*gi+1] : regs[2*gi];
                end else begin : g_inner
                    assign n1[gi] = read_reg1[gl] ? lvl[gl-1].n1[2*gi+1] : lvl[gl-1].n1[2*gi];
                    assign n2[gi] = read_reg2[gl] ? lvl[gl-1].n2[2*gi+1] : lvl[gl-1].n2[2*gi];
                end
            end
        end
    endgenerate

    assign read_data1 = lvl[ADDR_W-1].n1[0];
    assign read_data2 = lvl[ADDR_W-1].n2[0];

endmodule

// File: tb/tb_mips_registers.sv
// Register-file bench: directed scenarios plus random traffic against an array model.
module tb_mips_registers;
    import mips_registers_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] read_reg1, read_reg2, write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data1, read_data2;

    logic [DATA_W-1:0] model [0:NUM_REGS-1];
    bit                check_en = 1'b0;
    int                tests = 0;
    int                fails = 0;

    always #5 clk = ~clk;

    mips_registers dut (
        .clk        (clk),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] idx);
        return (idx == 0) ? '0 : model[idx];
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Continuous compare of both read ports against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("rd1_model", read_data1, model_rd(read_reg1));
            chk("rd2_model", read_data2, model_rd(read_reg2));
        end
    end

    // Apply the edge to the model, then move inputs shortly after it.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (reg_write && write_reg != 0) begin
            model[write_reg] = write_data;
        end
        #1;
    endtask

    task automatic drive(input int r1, input int r2, input int wr, input logic [DATA_W-1:0] wd, input bit we);
        read_reg1  = ADDR_W'(r1);
        read_reg2  = ADDR_W'(r2);
        write_reg  = ADDR_W'(wr);
        write_data = wd;
        reg_write  = we;
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check_en = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        reset = 1'b0;
        drive(0, 0, 7, 32'h0BAD_0BAD, 1'b1);
        repeat (2) tick();

        // Reset with a simultaneous write to r3: reset must win.
        drive(3, 3, 3, 32'hA5A5_A5A5, 1'b1);
        do_reset();
        drive(3, 3, 0, '0, 1'b0);
        @(negedge clk);
        chk("reset_beats_write", read_data1, 32'h0);

        for (int i = 0; i < NUM_REGS; i++) begin
            drive(i, NUM_REGS - 1 - i, 0, '0, 1'b0);
            @(negedge clk);
            chk("reset_zero_p1", read_data1, 32'h0);
            chk("reset_zero_p2", read_data2, 32'h0);
            tick();
        end

        drive(0, 0, 8, 32'hDEAD_BEEF, 1'b1);
        tick();
        drive(8, 8, 0, '0, 1'b0);
        @(negedge clk);
        chk("r8_port1", read_data1, 32'hDEAD_BEEF);
        chk("r8_port2", read_data2, 32'hDEAD_BEEF);
        drive(9, 8, 0, '0, 1'b0);
        @(negedge clk);
        chk("r9_still_zero", read_data1, 32'h0);

        drive(0, 8, 0, 32'hFFFF_FFFF, 1'b1);
        tick();
        drive(0, 8, 0, '0, 1'b0);
        @(negedge clk);
        chk("r0_discard", read_data1, 32'h0);
        chk("r0_no_side_effect", read_data2, 32'hDEAD_BEEF);

        drive(0, 0, 5, 32'h0000_0001, 1'b1);
        tick();
        drive(5, 0, 5, 32'h1234_5678, 1'b1);
        @(negedge clk);
        chk("no_bypass_before", read_data1, 32'h0000_0001);
        tick();
        drive(5, 0, 0, '0, 1'b0);
        @(negedge clk);
        chk("new_after_edge", read_data1, 32'h1234_5678);

        drive(0, 0, 4, 32'd7, 1'b1);
        tick();
        drive(0, 0, 6, 32'd5, 1'b1);
        tick();
        drive(4, 6, 0, '0, 1'b0);
        @(negedge clk);
        chk("sub_result", read_data1 - read_data2, 32'd2);
        chk("sub_zero_flag", DATA_W'(read_data1 == read_data2), 32'd0);
        drive(4, 4, 0, '0, 1'b0);
        @(negedge clk);
        chk("sub_same_result", read_data1 - read_data2, 32'd0);
        chk("sub_same_zero", DATA_W'(read_data1 == read_data2), 32'd1);

        // Writes land on the very first edge after reset drops.
        do_reset();
        drive(10, 10, 10, 32'd55, 1'b1);
        tick();
        drive(10, 4, 0, '0, 1'b0);
        @(negedge clk);
        chk("write_after_reset", read_data1, 32'd55);
        chk("r4_cleared", read_data2, 32'd0);
        tick();

        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, NUM_REGS - 1), $urandom_range(0, NUM_REGS - 1),
                  $urandom_range(0, NUM_REGS - 1), $urandom, ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_registers.md
MIPS_REGISTERS -- requirements
Module: mips_registers

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-index width (2**ADDR_W = 32 registers).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port read_reg1, input, ADDR_W, SHALL be the index for read port 1 (rs).
REQ-006 Port read_reg2, input, ADDR_W, SHALL be the index for read port 2 (rt).
REQ-007 Port write_reg, input, ADDR_W, SHALL be the write index (rd/rt as selected upstream).
REQ-008 Port write_data, input, DATA_W, SHALL be the write value (ALU result or memory data).
REQ-009 Port reg_write, input, 1 bit, SHALL be the write enable.
REQ-010 Port read_data1, output, DATA_W, SHALL be register[read_reg1], feeding ALU operand a.
REQ-011 Port read_data2, output, DATA_W, SHALL be register[read_reg2], feeding ALU operand b or the store-data path.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits, indexed 0..31.
REQ-013 Reads SHALL be combinational (zero-cycle latency) from the current register contents; there SHALL be no output register.
REQ-014 Register 0 SHALL always read as 32'h0000_0000 and SHALL never be written.
REQ-015 On a rising clk edge with reset=0, reg_write=1 and write_reg!=0, register[write_reg] SHALL take write_data.
REQ-016 With reg_write=0, no register SHALL change.
REQ-017 A write to index 0 with reg_write=1 SHALL be silently discarded, with no side effects on any other register.
REQ-018 A read of index N in the same cycle as a write to N SHALL return the old value until the edge and the new value after it; there is no write-to-read bypass.
REQ-019 Both read ports MAY address the same register; each SHALL return the identical value.
REQ-020 The outputs SHALL be free of X for any defined index once reset has been applied.

Reset
REQ-021 On a rising clk edge with reset=1, all 32 registers SHALL clear to 0; read_data1 and read_data2 SHALL then be 0 for every index.
REQ-022 reset=1 SHALL override reg_write=1 on the same edge; the write SHALL be lost.
REQ-023 While reset is asserted before its first edge, outputs SHALL reflect the prior contents because reads are asynchronous; the bench SHALL not check outputs in that window.
REQ-024 Deasserting reset SHALL allow writes on the next edge, with no extra recovery cycles.

Structure
REQ-025 DATA_W, ADDR_W and the zero-register index constant (REG_ZERO = 5'd0) SHALL live in the shared MIPS constants include, also used by the control and datapath blocks.
REQ-026 Each of registers 1..31 SHALL be one instance of sub-module reg32_en (DATA_W-bit, synchronous active-high reset, write enable); register 0 SHALL be a constant tie-off.
REQ-027 Write-enable decoding SHALL be a 5-to-32 decoder gated by reg_write.
REQ-028 Each read port SHALL be a 32:1 DATA_W-bit mux built from the existing mux primitives, matching the gate-level style of the datapath.

Verification
REQ-029 Reset then read all 32 indices on both ports -> every value 0.
REQ-030 Write 32'hDEAD_BEEF to reg 8, then read_reg1=8 and read_reg2=8 -> both 32'hDEAD_BEEF; reg 9 still 0.
REQ-031 Write 32'hFFFF_FFFF to reg 0, then read reg 0 -> 0; all other registers unchanged.
REQ-032 Same cycle: write 32'h1234_5678 to reg 5 while read_reg1=5 (previously 32'h0000_0001) -> 1 before the edge, 32'h1234_5678 after it.
REQ-033 reg_write=1, write_reg=3, write_data=32'hA5A5_A5A5 with reset=1 on the same edge -> reg 3 reads 0.
REQ-034 Load reg 4=7 and reg 6=5, drive read ports into alu32 with the subtract opcode -> result 2, ZERO=0; with both ports on reg 4 -> result 0, ZERO=1.
